// File: rtl/mips_control_signal_immediate_stage_if.sv
// -----------------------------------------------------------------------------
// mips_control_signal_immediate_stage_if
//   Handshake bundle between decode, the immediate stage and execute.
//   Request side : in_valid / in_ready / in_imm16 / in_extend / in_shift / in_tag
//   Response side: out_valid / out_ready / out_imm32 / out_tag
//   master : drives requests and out_ready (decode + execute side)
//   slave  : the immediate stage itself
// -----------------------------------------------------------------------------
interface mips_control_signal_immediate_stage_if #(
   parameter int TAG_W = 5
) ();
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_imm16;
   logic             in_extend;
   logic             in_shift;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_imm32;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_imm16, in_extend, in_shift, in_tag, out_ready,
      input  in_ready, out_valid, out_imm32, out_tag
   );

   modport slave (
      input  in_valid, in_imm16, in_extend, in_shift, in_tag, out_ready,
      output in_ready, out_valid, out_imm32, out_tag
   );
endinterface

// File: rtl/mips_control_signal_immediate_stage.sv
// -----------------------------------------------------------------------------
// mips_control_signal_immediate_stage
//   Expands a 16-bit MIPS immediate to 32 bits (sign/zero extend or LUI shift)
//   on entry and holds it in a 2-entry skid buffer (EMPTY / ONE / FULL) in
//   strict FIFO order. All outputs come straight from registers.
//
// Ports
//   clock       : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   flush       : empties the buffer on the next edge, beats accept/retire
//   bus         : slave modport of mips_control_signal_immediate_stage_if
//   stall_count : (optional) cycles with out_valid=1 and out_ready=0,
//                 saturating, cleared by reset only
//
// Configuration
//   MIPS_CONTROL_SIGNAL_IMMEDIATE_STAGE_STATS_EN : adds stall_count
// -----------------------------------------------------------------------------
module mips_control_signal_immediate_stage #(
   parameter int TAG_W = 5
) (
   input  logic clock,
   input  logic reset_n,
   input  logic flush,
   mips_control_signal_immediate_stage_if.slave bus
`ifdef MIPS_CONTROL_SIGNAL_IMMEDIATE_STAGE_STATS_EN
   ,
   output logic [15:0] stall_count
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0]      imm;
      logic [TAG_W-1:0] tag;
   } entry_t;

   function automatic logic [31:0] expand(input logic [15:0] imm16,
                                          input logic        extend,
                                          input logic        shift);
      if (shift)       return {imm16, 16'h0000};
      else if (extend) return {16'h0000, imm16};
      else             return {{16{imm16[15]}}, imm16};
   endfunction

   state_t state_q;
   entry_t head_q;
   entry_t tail_q;
   logic   in_ready_q;
   logic   out_valid_q;

   entry_t new_entry_d;
   logic   accept;
   logic   retire;

   assign new_entry_d = {expand(bus.in_imm16, bus.in_extend, bus.in_shift), bus.in_tag};
   assign accept      = bus.in_valid & in_ready_q;
   assign retire      = out_valid_q & bus.out_ready;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_imm32 = head_q.imm;
   assign bus.out_tag   = head_q.tag;

   // in_ready/out_valid are updated together with the state so they are
   // registered flags, never decoded from out_ready.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the two entry registers are reset too, because out_imm32 and
         // out_tag must read zero while reset is held.
         state_q     <= EMPTY;
         head_q      <= '0;
         tail_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every branch reads the pre-edge
         // values of head_q/tail_q (the FULL->ONE move depends on it).
         case (state_q)
            EMPTY: begin
               // First edge after reset arms in_ready here.
               in_ready_q <= 1'b1;
               if (accept) begin
                  head_q      <= new_entry_d;
                  state_q     <= ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ONE: begin
               if (accept && !retire) begin
                  tail_q     <= new_entry_d;
                  state_q    <= FULL;
                  in_ready_q <= 1'b0;
               end else if (retire && !accept) begin
                  state_q     <= EMPTY;
                  out_valid_q <= 1'b0;
               end else if (accept && retire) begin
                  head_q <= new_entry_d;
               end
            end
            FULL: begin
               // in_ready is low, so no accept can happen in this state.
               if (retire) begin
                  head_q     <= tail_q;
                  state_q    <= ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef MIPS_CONTROL_SIGNAL_IMMEDIATE_STAGE_STATS_EN
   logic [15:0] stall_count_q;

   // Deliberately not cleared by flush: the count spans redirects.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_count_q <= '0;
      end else if (out_valid_q && !bus.out_ready && (stall_count_q != 16'hFFFF)) begin
         stall_count_q <= stall_count_q + 16'd1;
      end
   end

   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_mips_control_signal_immediate_stage.sv
// -----------------------------------------------------------------------------
// tb_mips_control_signal_immediate_stage
//   Directed and random stimulus against a queue-based reference model of the
//   immediate stage. Define MIPS_CONTROL_SIGNAL_IMMEDIATE_STAGE_STATS_EN for
//   both files to also check stall_count.
// -----------------------------------------------------------------------------
module tb_mips_control_signal_immediate_stage;
   localparam int TAG_W = 5;

   logic clock;
   logic reset_n;
   logic flush;
`ifdef MIPS_CONTROL_SIGNAL_IMMEDIATE_STAGE_STATS_EN
   logic [15:0] stall_count;
`endif

   mips_control_signal_immediate_stage_if #(.TAG_W(TAG_W)) bus ();

   mips_control_signal_immediate_stage #(.TAG_W(TAG_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (flush),
      .bus     (bus)
`ifdef MIPS_CONTROL_SIGNAL_IMMEDIATE_STAGE_STATS_EN
      ,
      .stall_count (stall_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0]      imm;
      logic [TAG_W-1:0] tag;
   } ent_t;

   ent_t q[$];
   bit   armed;          // in_ready allowed (first edge after reset seen)
   int   stall_m;

   int vectors;
   int miscompares;

   function automatic logic [31:0] ref_imm(input logic [15:0] i, input logic e, input logic s);
      int v;
      if (s)      v = int'(i) * 65536;
      else if (e) v = int'(i);
      else        v = int'($signed(i));
      return 32'(v);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      check("in_ready", 32'(bus.in_ready), 32'(armed && q.size() < 2));
      if (q.size() > 0) begin
         check("out_imm32", bus.out_imm32, q[0].imm);
         check("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
      end
`ifdef MIPS_CONTROL_SIGNAL_IMMEDIATE_STAGE_STATS_EN
      check("stall_count", 32'(stall_count), 32'(stall_m));
`endif
   endtask

   // Drive one cycle of inputs, advance one edge, update the model, check.
   task automatic step(input logic v, input logic [15:0] imm, input logic ext,
                       input logic sh, input logic [TAG_W-1:0] tag,
                       input logic ordy, input logic fl);
      bit   acc;
      bit   ret;
      ent_t e;
      bus.in_valid  = v;
      bus.in_imm16  = imm;
      bus.in_extend = ext;
      bus.in_shift  = sh;
      bus.in_tag    = tag;
      bus.out_ready = ordy;
      flush         = fl;
      acc = v && armed && (q.size() < 2);
      ret = (q.size() > 0) && ordy;
      if ((q.size() > 0) && !ordy && stall_m < 65535) stall_m++;
      e.imm = ref_imm(imm, ext, sh);
      e.tag = tag;
      @(posedge clock);
      if (fl) q.delete();
      else begin
         if (ret) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      armed = 1'b1;
      #1;
      check_model();
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 16'h0000, 1'b0, 1'b0, '0, ordy, 1'b0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      q.delete();
      armed   = 1'b0;
      stall_m = 0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_imm32", bus.out_imm32, 32'd0);
      check("rst_out_tag", 32'(bus.out_tag), 32'd0);
`ifdef MIPS_CONTROL_SIGNAL_IMMEDIATE_STAGE_STATS_EN
      check("rst_stall_count", 32'(stall_count), 32'd0);
`endif
      repeat (2) @(posedge clock);
      #1;
      check("rst_hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      reset_n       = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_imm16  = '0;
      bus.in_extend = 1'b0;
      bus.in_shift  = 1'b0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;

      do_reset();

      // First edge after reset: in_ready rises, nothing accepted yet.
      step(1'b1, 16'h8001, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
      check("arm_in_ready", 32'(bus.in_ready), 32'd1);
      check("arm_no_accept", 32'(bus.out_valid), 32'd0);

      // Expansion cases, latency 1.
      step(1'b1, 16'h8001, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0);
      check("sext_8001", bus.out_imm32, 32'hFFFF8001);
      step(1'b1, 16'h8001, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
      check("zext_8001", bus.out_imm32, 32'h00008001);
      step(1'b1, 16'h1234, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
      check("lui_1234", bus.out_imm32, 32'h12340000);
      step(1'b1, 16'hFFFF, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      check("lui_ignores_ext", bus.out_imm32, 32'hFFFF0000);
      idle(1'b1);

      // Back-pressure: tags 1,2,3 back to back with out_ready=0.
      step(1'b1, 16'h0001, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
      step(1'b1, 16'h0002, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      step(1'b1, 16'h0003, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
      check("held_head_tag", 32'(bus.out_tag), 32'd1);
      step(1'b1, 16'h0003, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
      check("order_tag2", 32'(bus.out_tag), 32'd2);
      step(1'b1, 16'h0003, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
      check("order_tag3", 32'(bus.out_tag), 32'd3);
      idle(1'b1);
      check("drained", 32'(bus.out_valid), 32'd0);

      // Flush while FULL with a same-cycle request.
      step(1'b1, 16'h0011, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
      step(1'b1, 16'h0022, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0);
      step(1'b1, 16'h0033, 1'b0, 1'b0, 5'd7, 1'b0, 1'b1);
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);
      check("flush_in_ready", 32'(bus.in_ready), 32'd1);
      idle(1'b1);
      check("flush_no_entry", 32'(bus.out_valid), 32'd0);

      // Stall counting across a flush.
      do_reset();
      idle(1'b1);
      step(1'b1, 16'h0044, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0);
      repeat (5) idle(1'b0);
`ifdef MIPS_CONTROL_SIGNAL_IMMEDIATE_STAGE_STATS_EN
      check("stall_5", 32'(stall_count), 32'd5);
`endif
      step(1'b0, 16'h0000, 1'b0, 1'b0, '0, 1'b1, 1'b1);
`ifdef MIPS_CONTROL_SIGNAL_IMMEDIATE_STAGE_STATS_EN
      check("stall_after_flush", 32'(stall_count), 32'd5);
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom),
              1'($urandom), TAG_W'($urandom), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 30) == 0));
      end

      // Asynchronous reset while FULL.
      step(1'b1, 16'h0055, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0);
      step(1'b1, 16'h0066, 1'b0, 1'b0, 5'd11, 1'b0, 1'b0);
      step(1'b1, 16'h0077, 1'b0, 1'b0, 5'd12, 1'b0, 1'b0);
      check("pre_async_full", 32'(bus.in_ready), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_out_imm32", bus.out_imm32, 32'd0);
      do_reset();
      idle(1'b1);
      check("post_reset_empty", 32'(bus.out_valid), 32'd0);
      step(1'b1, 16'h7FFF, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0);
      check("post_reset_sext", bus.out_imm32, 32'h00007FFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mips_control_signal_immediate_stage.md
MIPS_CONTROL_SIGNAL_IMMEDIATE_STAGE -- requirements
Module: mips_control_signal_immediate_stage

Interface
REQ-001 SHALL have parameter TAG_W, default 5: width of the sideband tag carried with each immediate (destination register index).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  decode presents an immediate request.
REQ-005 SHALL have port in_ready  output  1  stage can accept a request this cycle.
REQ-006 SHALL have port in_imm16  input  16  raw instruction immediate.
REQ-007 SHALL have port in_extend  input  1  extend control: 0 = signed, 1 = unsigned.
REQ-008 SHALL have port in_shift  input  1  shift control: 0 = none, 1 = left by 16 (LUI).
REQ-009 SHALL have port in_tag  input  TAG_W  sideband tag.
REQ-010 SHALL have port out_valid  output  1  execute-side immediate available.
REQ-011 SHALL have port out_ready  input  1  execute consumes the immediate.
REQ-012 SHALL have port out_imm32  output  32  expanded immediate.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the entry at head.
REQ-014 SHALL have port flush  input  1  pipeline flush (branch redirect).

Function
REQ-015 Expansion SHALL be: shift=1 -> {imm16, 16'h0000}, regardless of extend; else extend=1 -> {16'h0000, imm16}; else {16{imm16[15]}, imm16}.
REQ-016 Expansion SHALL be computed on entry and stored; outputs SHALL be driven from registers only (no combinational in->out path).
REQ-017 The stage SHALL be a 2-entry skid buffer with states EMPTY, ONE, FULL.
REQ-018 Transfers: accept = in_valid & in_ready; retire = out_valid & out_ready.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, registered (not a function of out_ready).
REQ-020 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-021 Transitions: EMPTY --accept--> ONE; ONE --accept & !retire--> FULL; ONE --retire & !accept--> EMPTY; ONE --accept & retire--> ONE (new entry becomes head); FULL --retire--> ONE; all other cases hold state.
REQ-022 Ordering SHALL be strict FIFO; a new entry SHALL reach out_imm32 in the cycle after acceptance when the buffer was empty (latency 1).
REQ-023 Head contents SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 flush=1 SHALL force state EMPTY on the next edge, discarding both entries and any same-cycle accept; flush has priority over accept and retire.
REQ-025 In FULL, in_valid SHALL be ignored (no overwrite, no loss).

Reset
REQ-026 While reset_n=0: state EMPTY, out_valid=0, in_ready=0, out_imm32=0, out_tag=0, all counters 0.
REQ-027 in_ready SHALL become 1 on the first rising edge after reset_n deasserts; reset mid-transfer SHALL discard all entries.

Configuration
REQ-028 Macro MIPS_CONTROL_SIGNAL_IMMEDIATE_STAGE_STATS_EN defined: SHALL add output stall_count (16 bits), incremented each cycle with out_valid=1 and out_ready=0, saturating at 16'hFFFF, cleared by reset only (not by flush).
REQ-029 Macro undefined: stall_count port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, then in_imm16=16'h8001, extend=0, shift=0, out_ready=1 -> next cycle out_valid=1, out_imm32=32'hFFFF8001.
REQ-031 in_imm16=16'h8001, extend=1 -> out_imm32=32'h00008001; in_imm16=16'h1234, shift=1, extend=0 -> 32'h12340000.
REQ-032 out_ready=0, three back-to-back requests tags 1,2,3 -> in_ready=0 after second accept, tag 3 held off; then out_ready=1 -> tags emitted 1,2,3 in order, no loss.
REQ-033 FULL with flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, no entry retained.
REQ-034 STATS_EN defined, out_valid=1 with out_ready=0 for 5 cycles -> stall_count=5; flush -> stall_count stays 5.
REQ-035 reset_n pulsed low while FULL, asynchronous to clock -> out_valid=0 and out_imm32=0 immediately, without waiting for a clock edge.
